upower_seq_ctrl: RTL and testbench

//  Multi-cycle phase sequencer for the uPOWER core datapath (ALU + register file + memories).

---
 rtl/upower_seq_ctrl_if.sv | 47 ++++
 rtl/upower_seq_ctrl.sv | 157 +++++++++++++++
 tb/tb_upower_seq_ctrl.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/upower_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// upower_seq_ctrl_if : control/handshake bundle between the core and the
//                      uPOWER phase sequencer.
// Rev 1.0
// ============================================================================
interface upower_seq_ctrl_if #(
  parameter int CNT_W = 32,
  parameter int PC_W  = 32
);
  logic             start;
  logic             step_mode;
  logic             step;
  logic             halt_req;
  logic [5:0]       opcode;
  logic             is_mem;
  logic             wb_en;
  logic             imem_ready;
  logic             dmem_ready;
  logic [PC_W-1:0]  pc;
  logic [PC_W-1:0]  bp_addr;
  logic             imem_req;
  logic             ir_we;
  logic             alu_en;
  logic             dmem_req;
  logic             rf_we;
  logic             pc_we;
  logic             busy;
  logic             halted;
  logic             err;
  logic [CNT_W-1:0] retired;

  modport master (
    output start, step_mode, step, halt_req, opcode, is_mem, wb_en,
           imem_ready, dmem_ready, pc, bp_addr,
    input  imem_req, ir_we, alu_en, dmem_req, rf_we, pc_we, busy, halted,
           err, retired
  );

  modport slave (
    input  start, step_mode, step, halt_req, opcode, is_mem, wb_en,
           imem_ready, dmem_ready, pc, bp_addr,
    output imem_req, ir_we, alu_en, dmem_req, rf_we, pc_we, busy, halted,
           err, retired
  );
endinterface
`default_nettype wire

// File: rtl/upower_seq_ctrl.sv
`default_nettype none
// ============================================================================
// upower_seq_ctrl : multi-cycle FETCH/DECODE/EXEC/MEM/WB phase sequencer
//                   with run/halt/single-step and retired-instruction count.
// Optional macro  : UPOWER_SEQ_BREAKPOINT_EN (PC breakpoint pauses in DECODE)
// Rev 1.0
// ============================================================================
module upower_seq_ctrl #(
  parameter int         CNT_W    = 32,
  parameter int         PC_W     = 32,
  parameter logic [5:0] HALT_OPC = 6'd0,
  parameter int         MAX_WAIT = 15
) (
  input wire               clock,
  input wire               reset_n,
  upower_seq_ctrl_if.slave bus
);

  localparam int                WAIT_W    = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_PAUSE  = 3'd6,
    S_HALT   = 3'd7
  } state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  retired_q, retired_d;
  logic              err_q, err_d;

`ifdef UPOWER_SEQ_BREAKPOINT_EN
  logic bp_skip_q, bp_skip_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) bp_skip_q <= 1'b0;
    else          bp_skip_q <= bp_skip_d;
  end
`else
  wire w_unused_bp = ^{bus.pc, bus.bp_addr};
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      wait_q    <= '0;
      retired_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    retired_d    = retired_q;
    err_d        = err_q;
`ifdef UPOWER_SEQ_BREAKPOINT_EN
    bp_skip_d    = bp_skip_q;
`endif
    bus.imem_req = 1'b0;
    bus.ir_we    = 1'b0;
    bus.alu_en   = 1'b0;
    bus.dmem_req = 1'b0;
    bus.rf_we    = 1'b0;
    bus.pc_we    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) state_d = S_FETCH;
      end
      S_FETCH: begin
        bus.imem_req = 1'b1;
        if (bus.imem_ready) begin
          bus.ir_we = 1'b1;
          state_d   = S_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_HALT;
          err_d   = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_DECODE: begin
`ifdef UPOWER_SEQ_BREAKPOINT_EN
        // A breakpoint hit arms a one-shot skip so the resumed fetch of the
        // same PC executes instead of pausing again.
        bp_skip_d = 1'b0;
        if (bus.opcode == HALT_OPC) begin
          state_d = S_HALT;
        end else if ((bus.pc == bus.bp_addr) && !bp_skip_q) begin
          state_d   = S_PAUSE;
          bp_skip_d = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
`else
        if (bus.opcode == HALT_OPC) state_d = S_HALT;
        else                        state_d = S_EXEC;
`endif
      end
      S_EXEC: begin
        bus.alu_en = 1'b1;
        state_d    = bus.is_mem ? S_MEM : S_WB;
      end
      S_MEM: begin
        bus.dmem_req = 1'b1;
        if (bus.dmem_ready) begin
          state_d = S_WB;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_HALT;
          err_d   = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_WB: begin
        bus.pc_we = 1'b1;
        bus.rf_we = bus.wb_en;
        retired_d = retired_q + 1'b1;
        if (bus.halt_req)       state_d = S_HALT;
        else if (bus.step_mode) state_d = S_PAUSE;
        else                    state_d = S_FETCH;
      end
      S_PAUSE: begin
        if (bus.halt_req)  state_d = S_HALT;
        else if (bus.step) state_d = S_FETCH;
      end
      S_HALT: begin
        if (bus.start) begin
          state_d = S_FETCH;
          err_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) wait_d = '0;
  end

  assign bus.busy    = !((state_q == S_IDLE) || (state_q == S_HALT) || (state_q == S_PAUSE));
  assign bus.halted  = (state_q == S_HALT);
  assign bus.err     = err_q;
  assign bus.retired = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_upower_seq_ctrl.sv
`default_nettype none
// ============================================================================
// tb_upower_seq_ctrl : randomized instruction stream with a transaction-level
//                      reference model feeding a scoreboard of phase events.
// Rev 1.0
// ============================================================================
module tb_upower_seq_ctrl;
  localparam int              CNT_W = 4;
  localparam int              PC_W  = 32;
  localparam int              MW    = 15;
  localparam logic [5:0]      HOPC  = 6'd0;
  localparam logic [PC_W-1:0] BP    = 32'h0000_0100;
  localparam int              N     = 64;
`ifdef UPOWER_SEQ_BREAKPOINT_EN
  localparam bit BP_ON = 1'b1;
`else
  localparam bit BP_ON = 1'b0;
`endif

  typedef enum logic [1:0] {EV_RETIRE = 2'd0, EV_HALT = 2'd1, EV_PAUSE = 2'd2} ev_t;
  typedef struct {
    ev_t kind;
    int  lat;
    int  icnt;
    int  acnt;
    int  dcnt;
    int  rf;
    int  ret;
    int  err;
  } exp_t;

  exp_t sb[$];
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  // per-instruction knobs
  int idly = 0, ddly = 0, op = 1, mem = 0, wbe = 0, hr = 0, sm = 0, ph = 0;
  logic [PC_W-1:0] pcv = '0;
  int ret_m = 0;
  bit bp_skip = 1'b0;

  upower_seq_ctrl_if #(.CNT_W(CNT_W), .PC_W(PC_W)) ifc ();

  upower_seq_ctrl #(
    .CNT_W(CNT_W), .PC_W(PC_W), .HALT_OPC(HOPC), .MAX_WAIT(MW)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (ifc)
  );

  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: wait bound expired, got timeout expected event", name);
  endtask

  function automatic int outs();
    return int'({ifc.imem_req, ifc.ir_we, ifc.alu_en, ifc.dmem_req, ifc.rf_we,
                 ifc.pc_we, ifc.busy, ifc.halted, ifc.err});
  endfunction

  // memories: ready on the (dly+1)-th request cycle, random noise when idle
  int icyc = 0, dcyc = 0;
  always @(negedge clock) begin
    if (ifc.imem_req) begin ifc.imem_ready = (icyc == idly); icyc++; end
    else begin icyc = 0; ifc.imem_ready = 1'($urandom_range(0, 1)); end
    if (ifc.dmem_req) begin ifc.dmem_ready = (dcyc == ddly); dcyc++; end
    else begin dcyc = 0; ifc.dmem_ready = 1'($urandom_range(0, 1)); end
  end

  // monitor: accumulate phase activity, pop and compare at each event
  int m_busy = 0, m_i = 0, m_a = 0, m_d = 0;
  bit p_busy = 1'b0, p_halt = 1'b0;

  task automatic compare_ev(input ev_t k);
    exp_t e;
    if (sb.size() == 0) begin
      check("unexpected_event", int'(k), -1);
    end else begin
      e = sb.pop_front();
      check("event_kind", int'(k), int'(e.kind));
      check("latency", m_busy, e.lat);
      check("imem_cycles", m_i, e.icnt);
      check("alu_cycles", m_a, e.acnt);
      check("dmem_cycles", m_d, e.dcnt);
      if (k == EV_RETIRE) check("rf_we", int'(ifc.rf_we), e.rf);
      check("retired", int'(ifc.retired), e.ret);
      check("err", int'(ifc.err), e.err);
    end
    m_busy = 0; m_i = 0; m_a = 0; m_d = 0;
  endtask

  always @(negedge clock) begin
    if (!reset_n) begin
      m_busy = 0; m_i = 0; m_a = 0; m_d = 0;
      p_busy = 1'b0; p_halt = 1'b0;
    end else begin
      m_busy += int'(ifc.busy);
      m_i    += int'(ifc.imem_req);
      m_a    += int'(ifc.alu_en);
      m_d    += int'(ifc.dmem_req);
      if (ifc.pc_we)                             compare_ev(EV_RETIRE);
      else if (ifc.halted && !p_halt)            compare_ev(EV_HALT);
      else if (p_busy && !ifc.busy && !ifc.halted) compare_ev(EV_PAUSE);
      p_busy = ifc.busy;
      p_halt = ifc.halted;
    end
  end

  function automatic void push(input ev_t k, input int lat, input int ic, input int ac,
                               input int dc, input int rf, input int er);
    exp_t e;
    e.kind = k; e.lat = lat; e.icnt = ic; e.acnt = ac; e.dcnt = dc;
    e.rf = rf; e.ret = ret_m; e.err = er;
    sb.push_back(e);
  endfunction

  // reference model: whole-instruction outcome from the knobs
  task automatic model_push(output bit ends_retire, output bit bp_hit);
    int f, m;
    ends_retire = 1'b0;
    bp_hit      = 1'b0;
    f = (idly >= MW) ? MW : idly + 1;
    if (idly >= MW) begin push(EV_HALT, f, f, 0, 0, 0, 1); return; end
    if (op == int'(HOPC)) begin bp_skip = 1'b0; push(EV_HALT, f + 1, f, 0, 0, 0, 0); return; end
    if (BP_ON && (pcv == BP) && !bp_skip) begin
      bp_hit = 1'b1;
      push(EV_PAUSE, f + 1, f, 0, 0, 0, 0);
    end
    bp_skip = 1'b0;
    if (mem != 0 && ddly >= MW) begin push(EV_HALT, f + 2 + MW, f, 1, MW, 0, 1); return; end
    m = (mem != 0) ? ddly + 1 : 0;
    push(EV_RETIRE, f + 3 + m, f, 1, m, wbe, 0);
    ret_m = (ret_m + 1) % (1 << CNT_W);
    ends_retire = 1'b1;
    if (hr != 0) push(EV_HALT, 0, 0, 0, 0, 0, 0);
    else if (sm != 0) begin
      push(EV_PAUSE, 0, 0, 0, 0, 0, 0);
      if (ph != 0) push(EV_HALT, 0, 0, 0, 0, 0, 0);
    end
  endtask

  task automatic pulse(input int which);
    if (which == 1) ifc.start = 1'b1; else ifc.step = 1'b1;
    @(posedge clock); #1;
    ifc.start = 1'b0;
    ifc.step  = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    do begin @(posedge clock); #1; n++; end
    while (!(ifc.pc_we || ifc.halted) && n < 200);
    if (n >= 200) bound_fail(name);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    do begin @(posedge clock); #1; n++; end
    while (ifc.busy && n < 200);
    if (n >= 200) bound_fail(name);
  endtask

  function automatic int rnd_dly();
    int r = int'($urandom_range(0, 19));
    if (r < 16) return r % 4;
    if (r == 16) return MW - 1;
    if (r == 17) return MW;
    return 0;
  endfunction

  task automatic gen_knobs(input int i);
    op = int'($urandom_range(1, 63)); mem = 0; wbe = int'($urandom_range(0, 1));
    idly = 0; ddly = 0; hr = 0; sm = 0; ph = 0;
    pcv = BP + 32'(4 * $urandom_range(1, 50));
    case (i)
      0, 1, 2: ;
      3:  begin mem = 1; ddly = 3; end
      4:  idly = MW;
      5:  idly = MW - 1;
      6:  begin mem = 1; ddly = MW; end
      7:  begin mem = 1; ddly = MW - 1; end
      8:  sm = 1;
      9:  begin sm = 1; ph = 1; end
      10: op = 0;
      11: begin hr = 1; sm = 1; end
      12: pcv = BP;
      N - 1: hr = 1;
      default: begin
        if ($urandom_range(0, 9) == 0) op = 0;
        mem  = int'($urandom_range(0, 1));
        idly = rnd_dly();
        ddly = rnd_dly();
        sm   = ($urandom_range(0, 3) == 0) ? 1 : 0;
        hr   = ($urandom_range(0, 6) == 0) ? 1 : 0;
        ph   = ($urandom_range(0, 3) == 0) ? 1 : 0;
        if ($urandom_range(0, 3) == 0) pcv = BP;
      end
    endcase
  endtask

  initial begin : driver
    int  resume;
    bit  ends_retire, bp_hit;
    int  n;
    ifc.start = 1'b0; ifc.step = 1'b0; ifc.step_mode = 1'b0; ifc.halt_req = 1'b0;
    ifc.opcode = 6'd1; ifc.is_mem = 1'b0; ifc.wb_en = 1'b0;
    ifc.pc = '0; ifc.bp_addr = BP;
    repeat (3) @(posedge clock);
    #1;
    check("reset_outputs", outs(), 0);
    check("reset_retired", int'(ifc.retired), 0);
    reset_n = 1'b1;
    resume = 1;

    for (int i = 0; i < N; i++) begin
      gen_knobs(i);
      ifc.opcode = op[5:0]; ifc.is_mem = mem[0]; ifc.wb_en = wbe[0];
      ifc.step_mode = sm[0]; ifc.halt_req = 1'b0; ifc.pc = pcv;
      model_push(ends_retire, bp_hit);
      if (resume == 1) begin
        if ($urandom_range(0, 1) == 1) pulse(2);
        pulse(1);
      end else if (resume == 2) begin
        if ($urandom_range(0, 1) == 1) pulse(1);
        pulse(2);
      end
      ifc.halt_req = hr[0];
      if (bp_hit) begin
        wait_idle("bp_pause_wait");
        pulse(2);
      end
      wait_done("instr_end_wait");
      if (ends_retire) begin
        @(posedge clock); #1;
        if (hr != 0) resume = 1;
        else if (sm != 0) begin
          if (ph != 0) begin
            ifc.halt_req = 1'b1;
            @(posedge clock); #1;
            ifc.halt_req = 1'b0;
            resume = 1;
          end else resume = 2;
        end else resume = 0;
      end else resume = 1;
    end

    repeat (2) @(posedge clock);
    #1;
    check("scoreboard_drained", sb.size(), 0);

    // asynchronous reset in the middle of a load's EXEC phase
    idly = 0; ddly = 3; ifc.opcode = 6'd5; ifc.is_mem = 1'b1; ifc.halt_req = 1'b0;
    ifc.step_mode = 1'b0; ifc.pc = BP + 32'h40;
    pulse(1);
    n = 0;
    while (!ifc.alu_en && n < 20) begin @(posedge clock); #1; n++; end
    if (n >= 20) bound_fail("exec_wait");
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_outputs", outs(), 0);
    check("async_reset_retired", int'(ifc.retired), 0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    idly = 40;
    pulse(2);
    check("step_ignored_idle", int'(ifc.busy), 0);
    pulse(1);
    check("start_fetch", int'(ifc.imem_req), 1);
    repeat (3) @(posedge clock);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
